// File: rtl/baud_detect.sv
// baud_detect: auto-baud detector. Times the falling edges of a 0x55 sync
// character on rx, derives the bit period and maps it to rate code 1..5.
// Optional macro BAUD_DETECT_GLITCH_FILTER_EN adds a 4-cycle stability filter
// on the synchronised rx level before edge detection.
module baud_detect #(
   parameter int IDLE_CYCLES = 20000,
   parameter int MAX_SPAN    = 100000,
   parameter int CNT_W       = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic        det_start,
   output logic        busy,
   output logic        det_done,
   output logic        det_err,
   output logic [3:0]  baud_code,
   output logic [15:0] bit_period
);

   localparam logic [CNT_W-1:0] L_IDLE_END = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_MAX      = CNT_W'(MAX_SPAN);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_IDLE, S_WAIT_START, S_MEASURE, S_CLASSIFY
   } state_t;

   state_t             r_state, w_state_nxt;
   logic               r_rx_m, r_rx_s, r_lvl_d;
   logic               w_lvl, w_fall;
   logic [CNT_W-1:0]   r_idle_cnt, r_span;
   logic [1:0]         r_fall_cnt;
   logic               w_done_nxt, w_err_nxt;
   logic [CNT_W-1:0]   w_p, w_nom, w_diff;
   logic [3:0]         w_code;
   logic               w_inband, w_ok;

   // two-flop synchroniser for the asynchronous line, plus delayed level for edges
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_m  <= 1'b1;
         r_rx_s  <= 1'b1;
         r_lvl_d <= 1'b1;
      end else begin
         r_rx_m  <= rx;
         r_rx_s  <= r_rx_m;
         r_lvl_d <= w_lvl;
      end
   end

`ifdef BAUD_DETECT_GLITCH_FILTER_EN
   logic       r_flt;
   logic [1:0] r_flt_cnt;

   // level follows rx_s only after 4 consecutive cycles at the new value;
   // every edge is delayed equally so the measured span is unaffected
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flt     <= 1'b1;
         r_flt_cnt <= 2'd0;
      end else if (r_rx_s == r_flt) begin
         r_flt_cnt <= 2'd0;
      end else if (r_flt_cnt == 2'd3) begin
         r_flt     <= r_rx_s;
         r_flt_cnt <= 2'd0;
      end else begin
         r_flt_cnt <= r_flt_cnt + 2'd1;
      end
   end

   assign w_lvl = r_flt;
`else
   assign w_lvl = r_rx_s;
`endif

   assign w_fall = r_lvl_d & ~w_lvl;
   assign busy   = (r_state != S_IDLE);

   // span covers 8 bit periods, so the period is span/8 (truncating)
   assign w_p = r_span >> 3;

   // nearest-rate banding and the +/-6.25% tolerance window around the nominal
   always_comb begin
      w_code   = 4'd5;
      w_nom    = CNT_W'(867);
      w_inband = 1'b1;
      if      (w_p >= CNT_W'(7813)) begin w_code = 4'd1; w_nom = CNT_W'(10417); end
      else if (w_p >= CNT_W'(3907)) begin w_code = 4'd2; w_nom = CNT_W'(5209);  end
      else if (w_p >= CNT_W'(2171)) begin w_code = 4'd3; w_nom = CNT_W'(2605);  end
      else if (w_p >= CNT_W'(1302)) begin w_code = 4'd4; w_nom = CNT_W'(1737);  end
      else if (w_p >= CNT_W'(650))  begin w_code = 4'd5; w_nom = CNT_W'(867);   end
      else                                w_inband = 1'b0;
      w_diff = (w_p >= w_nom) ? (w_p - w_nom) : (w_nom - w_p);
      w_ok   = w_inband && (w_diff <= (w_nom >> 4));
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next-state and result strobes
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE:       if (det_start) w_state_nxt = S_WAIT_IDLE;
         S_WAIT_IDLE:  if (w_lvl && r_idle_cnt == L_IDLE_END) w_state_nxt = S_WAIT_START;
         S_WAIT_START: if (w_fall) w_state_nxt = S_MEASURE;
         S_MEASURE: begin
            if (w_fall && r_fall_cnt == 2'd3) begin
               w_state_nxt = S_CLASSIFY;
            end else if (r_span == L_MAX) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_CLASSIFY: begin
            w_done_nxt  = w_ok;
            w_err_nxt   = ~w_ok;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // counters, span latch and held results
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idle_cnt <= '0;
         r_span     <= '0;
         r_fall_cnt <= 2'd0;
         det_done   <= 1'b0;
         det_err    <= 1'b0;
         baud_code  <= 4'd5;
         bit_period <= 16'd0;
      end else begin
         det_done <= w_done_nxt;
         det_err  <= w_err_nxt;
         case (r_state)
            S_IDLE: begin
               r_idle_cnt <= '0;
               r_span     <= '0;
               r_fall_cnt <= 2'd0;
            end
            S_WAIT_IDLE: r_idle_cnt <= w_lvl ? r_idle_cnt + 1'b1 : '0;
            S_WAIT_START: begin
               r_fall_cnt <= 2'd0;
               if (w_fall) r_span <= CNT_W'(1);
            end
            S_MEASURE: begin
               if (w_fall) r_fall_cnt <= r_fall_cnt + 2'd1;
               // the 4th falling edge freezes span at exactly 8 bit periods
               if (!(w_fall && r_fall_cnt == 2'd3)) r_span <= r_span + 1'b1;
            end
            S_CLASSIFY: begin
               if (w_ok) begin
                  baud_code  <= w_code;
                  bit_period <= 16'(w_p);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
